ltile_clb_ccff_loader: RTL
==========================

// Module: ltile_clb_ccff_loader
// PURPOSE
//  Configuration-chain loader that feeds ccff_head of an ltile CLB chain (frac_lut4 + output-mux mems).
//  Accepts bitstream words over valid/ready, serializes them LSB-first onto ccff_head with a shift enable.
//  The shift enable drives the chain's prog_clk gate, so upstream stalls never corrupt the chain.
//  Captures bits leaving ccff_tail and returns them as readback words for bitstream verification.
// PARAMETERS
//  CHAIN_LEN   19  number of config FFs in the downstream chain (16 LUT + 1 mode + 2 mux mem)
//  DATA_WIDTH  8   width of s_data / rd_data words
//  NWORDS      ceil(CHAIN_LEN/DATA_WIDTH); derived localparam, not overridable
// PORTS
//  prog_clk       in   1           programming clock; all state updates on its rising edge
//  prog_resetn    in   1           synchronous, active-low reset
//  start          in   1           request a full chain load; sampled in IDLE only
//  busy           out  1           high from the cycle after accepted start until DONE exits
//  done           out  1           one-cycle pulse when all CHAIN_LEN bits are shifted
//  s_data         in   DATA_WIDTH  bitstream word; bit 0 shifted first
//  s_valid        in   1           s_data valid
//  s_ready        out  1           loader can take a word; transfer = s_valid & s_ready
//  ccff_head      out  1           serial config bit to chain head
//  ccff_shift_en  out  1           chain clock enable; chain shifts on edges where high
//  ccff_tail      in   1           chain tail bit (current content of the last FF)
//  rd_data        out  DATA_WIDTH  readback word; bit 0 = first bit out of tail
//  rd_valid       out  1           one-cycle qualifier for rd_data; no backpressure
// BEHAVIOUR
//  Reset (prog_resetn=0 at an edge): state=IDLE; busy, done, s_ready, ccff_shift_en, rd_valid = 0.
//   ccff_head=0, rd_data=0, and all counters and the word register are cleared.
//  FSM: IDLE -(start)-> LOAD -(total bit count==CHAIN_LEN-1 shifting)-> DONE -> IDLE (DONE lasts 1 cycle).
//  IDLE: s_ready=0; start at edge t moves to LOAD, busy=1 and s_ready=1 from t+1.
//   s_valid in the start cycle is not accepted.
//  LOAD: word register wreg with full flag wfull, bit index bcnt, total count tcnt (0..CHAIN_LEN-1).
//   s_ready = !wfull | (wfull & bcnt==DATA_WIDTH-1 & tcnt!=CHAIN_LEN-1), giving back-to-back words without bubbles.
//   s_ready is also low once the last word (index NWORDS-1) is accepted.
//   ccff_shift_en = wfull; ccff_head = wreg[bcnt]; both from registers, no comb path from s_valid.
//   Per shift cycle: bcnt++, tcnt++, and ccff_tail is captured into rd shift reg at position bcnt.
//   The tail capture happens before the chain edge.
//   Last word: only CHAIN_LEN-(NWORDS-1)*DATA_WIDTH bits are shifted; upper bits are discarded.
//  Stall: wfull=0 forces shift_en=0, and the chain and counters hold. Gaps of any length are legal.
//  Readback: rd_valid pulses the cycle after each DATA_WIDTH-th captured bit.
//   It also pulses after the final bit, with the final partial word zero-padded in its upper bits.
//   Exactly NWORDS pulses occur per load.
//  DONE: done=1, busy=1, shift_en=0, s_ready=0; next cycle IDLE, busy=0.
//  Ordering: first bit shifted ends in the chain FF farthest from head (adjacent to ccff_tail).
//  start while busy: ignored. Reset mid-LOAD: shift_en=0 from next cycle and chain contents undefined.
//   The host must issue a new full load.
//  Latency: start -> first shift_en = 2 cycles minimum (word accept cycle + shift).
//   Best-case load = CHAIN_LEN+3 cycles from start to done.
// TESTING
//  1 CHAIN_LEN=19,DW=8, start then words 0xA5,0x3C,0x07 with no gaps -> 19 contiguous shift_en cycles.
//    ccff_head = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1; done pulses 1 cycle after the last shift.
//  2 Same words with s_valid low 3 cycles between words -> shift_en drops exactly during gaps.
//    Chain model ends identical to test 1; done still a single pulse.
//  3 Chain model preloaded with 19'h5A5A5 (tail=bit0) -> rd_data = 0xA5, 0xA5, 0x05.
//    Third word bits[7:3] = 0; three rd_valid pulses total.
//  4 prog_resetn low for 1 cycle after 10 shifts -> next cycle shift_en=0, busy=0, s_ready=0, no done.
//    A fresh start then loads 19 bits correctly.
//  5 start asserted in LOAD, and start+s_valid together in IDLE -> start in LOAD ignored.
//    The word offered with start is not consumed; s_ready rises one cycle later.
//  6 Override CHAIN_LEN=16 -> exactly 2 words accepted, 16 shifts, 2 rd_valid, s_ready low after word 2.

Source files
------------

// File: rtl/ltile_clb_ccff_loader_if.sv
// Word stream into the loader and readback words out of it.
// The loader is the slave: it consumes s_data and produces rd_data.
interface ltile_clb_ccff_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output s_data, s_valid,
    input  s_ready, rd_data, rd_valid
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/ltile_clb_ccff_loader.sv
// Serializes bitstream words LSB-first into an ltile CLB config chain
// and returns the bits leaving the chain tail as readback words.
module ltile_clb_ccff_loader #(
  parameter int CHAIN_LEN  = 19,
  parameter int DATA_WIDTH = 8
) (
  input  logic prog_clk,
  input  logic prog_resetn,
  input  logic start,
  output logic busy,
  output logic done,
  ltile_clb_ccff_loader_if.slave bus,
  output logic ccff_head,
  output logic ccff_shift_en,
  input  logic ccff_tail
);
  localparam int NWORDS =
    (CHAIN_LEN + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BW =
    DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int TW =
    CHAIN_LEN > 1 ? $clog2(CHAIN_LEN) : 1;
  localparam int WW = $clog2(NWORDS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TLAST = TW'(CHAIN_LEN - 1);
  localparam logic [WW-1:0] WLAST = WW'(NWORDS);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] wreg;
  logic                  wfull;
  logic [BW-1:0]         bcnt;
  logic [TW-1:0]         tcnt;
  logic [WW-1:0]         wcnt;
  logic [DATA_WIDTH-1:0] rsr;
  logic [DATA_WIDTH-1:0] rsr_next;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_v;

  logic shift;
  logic word_end;
  logic last;
  logic take;

  assign shift    = (state == LOAD) & wfull;
  assign last     = (tcnt == TLAST);
  assign word_end = (bcnt == BLAST) | last;

  // Refill in the same cycle the final bit of a word leaves,
  // except on the chain's last bit.
  assign bus.s_ready = (state == LOAD) & (wcnt != WLAST) &
                       (!wfull | ((bcnt == BLAST) & !last));
  assign take = bus.s_valid & bus.s_ready;

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign ccff_shift_en = shift;
  assign ccff_head     = wreg[bcnt];
  assign bus.rd_data   = rd_q;
  assign bus.rd_valid  = rd_v;

  always_comb begin
    rsr_next       = rsr;
    rsr_next[bcnt] = ccff_tail;
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_resetn) begin
      state <= IDLE;
      wreg  <= '0;
      wfull <= 1'b0;
      bcnt  <= '0;
      tcnt  <= '0;
      wcnt  <= '0;
      rsr   <= '0;
      rd_q  <= '0;
      rd_v  <= 1'b0;
    end else begin
      rd_v <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) state <= LOAD;
        end
        LOAD: begin
          if (shift) begin
            bcnt <= bcnt + 1'b1;
            tcnt <= tcnt + 1'b1;
            rsr  <= rsr_next;
            if (word_end) begin
              rd_q  <= rsr_next;
              rd_v  <= 1'b1;
              rsr   <= '0;
              bcnt  <= '0;
              wfull <= 1'b0;
            end
            if (last) begin
              state <= DONE;
              tcnt  <= '0;
              wcnt  <= '0;
            end
          end
          if (take) begin
            wreg  <= bus.s_data;
            wfull <= 1'b1;
            wcnt  <= wcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
